// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
// Optional bubble counter is built only when ID_EX_PERF_EN is defined.
module id_ex_reg #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic [1:0]      id_ALUOp,
    input  logic [2:0]      id_Funct3,
    input  logic [6:0]      id_Funct7,
    input  logic            id_RegWrite,
    input  logic            id_MemRead,
    input  logic            id_MemWrite,
    input  logic            id_MemtoReg,
    input  logic            id_ALUSrc,
    input  logic            id_Branch,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [1:0]      ex_ALUOp,
    output logic [2:0]      ex_Funct3,
    output logic [6:0]      ex_Funct7,
    output logic            ex_RegWrite,
    output logic            ex_MemRead,
    output logic            ex_MemWrite,
    output logic            ex_MemtoReg,
    output logic            ex_ALUSrc,
    output logic            ex_Branch,
    output logic            ld_use_stall_o,
    output logic [15:0]     bubble_cnt_o
);

    // A bubble is the all-zero value of this struct.
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [1:0]      alu_op;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            mem_to_reg;
        logic            alu_src;
        logic            branch;
    } pipe_t;

    pipe_t pipe_q;
    pipe_t pipe_d;
    logic  bubble_load;

    assign ld_use_stall_o = id_valid & pipe_q.valid & pipe_q.mem_read &
                            (pipe_q.rd != 5'd0) &
                            ((pipe_q.rd == id_rs1) | (pipe_q.rd == id_rs2));

    // Per edge: flush beats stall, stall beats hazard, hazard beats a normal load.
    // A hazard seen under stall stays asserted and becomes a bubble once stall drops.
    always_comb begin
        pipe_d      = pipe_q;
        bubble_load = 1'b0;
        if (flush_i) begin
            pipe_d      = '0;
            bubble_load = 1'b1;
        end else if (stall_i) begin
            pipe_d = pipe_q;
        end else if (ld_use_stall_o) begin
            pipe_d      = '0;
            bubble_load = 1'b1;
        end else if (!id_valid) begin
            pipe_d = '0;
        end else begin
            pipe_d = '{valid: 1'b1, pc: id_pc, rs1_data: id_rs1_data,
                       rs2_data: id_rs2_data, imm: id_imm, rs1: id_rs1,
                       rs2: id_rs2, rd: id_rd, alu_op: id_ALUOp,
                       funct3: id_Funct3, funct7: id_Funct7,
                       reg_write: id_RegWrite, mem_read: id_MemRead,
                       mem_write: id_MemWrite, mem_to_reg: id_MemtoReg,
                       alu_src: id_ALUSrc, branch: id_Branch};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign ex_valid    = pipe_q.valid;
    assign ex_pc       = pipe_q.pc;
    assign ex_rs1_data = pipe_q.rs1_data;
    assign ex_rs2_data = pipe_q.rs2_data;
    assign ex_imm      = pipe_q.imm;
    assign ex_rs1      = pipe_q.rs1;
    assign ex_rs2      = pipe_q.rs2;
    assign ex_rd       = pipe_q.rd;
    assign ex_ALUOp    = pipe_q.alu_op;
    assign ex_Funct3   = pipe_q.funct3;
    assign ex_Funct7   = pipe_q.funct7;
    assign ex_RegWrite = pipe_q.reg_write;
    assign ex_MemRead  = pipe_q.mem_read;
    assign ex_MemWrite = pipe_q.mem_write;
    assign ex_MemtoReg = pipe_q.mem_to_reg;
    assign ex_ALUSrc   = pipe_q.alu_src;
    assign ex_Branch   = pipe_q.branch;

`ifdef ID_EX_PERF_EN
    logic [15:0] bubble_cnt_q;
    logic [15:0] bubble_cnt_d;

    // Saturating: the count sticks at all-ones instead of wrapping.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (bubble_load && (bubble_cnt_q != 16'hFFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_q <= 16'd0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bubble_cnt_o = bubble_cnt_q;
`else
    logic unused_bubble_load;
    assign unused_bubble_load = bubble_load;
    assign bubble_cnt_o       = 16'd0;
`endif

endmodule
